simproc_host_ctrl: RTL and testbench

Host-side sequencer for the simproc core. It arbitrates the core's single 8-bit memory port between the host and the core, and it owns the core's debug inputs (`pc_set_val`, `pc_set_wr`, `run`). The host uses it to load or read memory, then start the core at a chosen PC for N instructions or free-running, and stop it. It sits between the host command link, the simproc core and the program/data memory (combinational read, synchronous write).

---
 rtl/simproc_pkg.sv | 42 ++++
 rtl/simproc_host_ctrl_if.sv | 25 ++
 rtl/simproc_mem_mux.sv | 29 ++
 rtl/simproc_host_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_simproc_host_ctrl.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/simproc_pkg.sv
// Shared types and helpers for the simproc host-side sequencer.
package simproc_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;

  // Host command opcodes as carried on cmd_op.
  typedef enum logic [1:0] {
    OP_MEM_WR = 2'b00,
    OP_MEM_RD = 2'b01,
    OP_RUN    = 2'b10,
    OP_STOP   = 2'b11
  } host_op_t;

  // Sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MEM_WR  = 3'd1,
    ST_MEM_RD  = 3'd2,
    ST_SET_PC  = 3'd3,
    ST_START   = 3'd4,
    ST_RUNNING = 3'd5,
    ST_DRAIN   = 3'd6
  } ctrl_state_t;

  // Latched command payload: memory address / start PC and write data / count.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } host_cmd_t;

  // Increment that sticks at all-ones.
  function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
    return (v == '1) ? v : v + DATA_W'(1);
  endfunction

  // The core owns the memory port from START until the run has drained.
  function automatic logic core_owns(input ctrl_state_t s);
    return (s == ST_START) || (s == ST_RUNNING) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/simproc_host_ctrl_if.sv
// Host command / response link of the simproc host controller.
interface simproc_host_ctrl_if;
  import simproc_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  host_op_t          cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;

  // Host side issues commands and collects responses.
  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data
  );

  // Controller side accepts commands and returns responses.
  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data,
    output cmd_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/simproc_mem_mux.sv
// Memory port select between the controller's latched request and the core.
module simproc_mem_mux
  import simproc_pkg::*;
(
  input  logic              owner,      // 1: core drives the port
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_din,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_din,
  input  logic              core_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we
);

  // Pass the owner's request straight to memory.
  always_comb begin
    mem_addr = host_addr;
    mem_din  = host_din;
    mem_we   = host_we;
    if (owner) begin
      mem_addr = core_addr;
      mem_din  = core_din;
      mem_we   = core_we;
    end
  end

endmodule

// File: rtl/simproc_host_ctrl.sv
// Host-side sequencer: memory load/read, PC set, run/stop of the simproc core.
module simproc_host_ctrl
  import simproc_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  simproc_host_ctrl_if.slave  host,
  output logic                busy,
  input  logic [ADDR_W-1:0]   core_mem_addr,
  input  logic [DATA_W-1:0]   core_mem_din,
  input  logic                core_mem_we,
  output logic [DATA_W-1:0]   core_mem_dout,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_din,
  output logic                mem_we,
  input  logic [DATA_W-1:0]   mem_dout,
  output logic [ADDR_W-1:0]   core_pc_set_val,
  output logic                core_pc_set_wr,
  output logic                core_run,
  input  logic                core_halt,
  input  logic                core_done
);

  ctrl_state_t       state_q, state_d;
  host_cmd_t         cmd_q, cmd_d;
  logic [DATA_W-1:0] remaining_q, remaining_d;
  logic [DATA_W-1:0] retired_q, retired_d;
  logic              stop_req_q, stop_req_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              busy_q, busy_d;
  logic              owner_q, owner_d;
  logic              own_we_q, own_we_d;
  logic [ADDR_W-1:0] pc_set_val_q, pc_set_val_d;
  logic              pc_set_wr_q, pc_set_wr_d;
  logic              core_run_q, core_run_d;

  logic cmd_ready;
  logic accept;

  // In RUNNING only a STOP may be taken, so ready follows cmd_op there.
  assign cmd_ready = (state_q == ST_IDLE) ||
                     ((state_q == ST_RUNNING) && (host.cmd_op == OP_STOP));
  assign accept    = host.cmd_valid && cmd_ready;

  assign host.cmd_ready = cmd_ready;
  assign host.rsp_valid = rsp_valid_q;
  assign host.rsp_data  = rsp_data_q;

  assign busy            = busy_q;
  assign core_pc_set_val = pc_set_val_q;
  assign core_pc_set_wr  = pc_set_wr_q;
  assign core_run        = core_run_q;
  assign core_mem_dout   = mem_dout;

  // Next state, counters, response, and next-cycle values of registered outputs.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    remaining_d = remaining_q;
    retired_d   = retired_q;
    stop_req_d  = stop_req_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cmd_d.addr = host.cmd_addr;
          cmd_d.data = host.cmd_data;
          unique case (host.cmd_op)
            OP_MEM_WR: state_d = ST_MEM_WR;
            OP_MEM_RD: state_d = ST_MEM_RD;
            OP_RUN:    state_d = ST_SET_PC;
            OP_STOP: begin
              rsp_valid_d = 1'b1;
              rsp_data_d  = '0;
            end
          endcase
        end
      end
      ST_MEM_WR: begin
        rsp_valid_d = 1'b1;
        rsp_data_d  = cmd_q.data;
        state_d     = ST_IDLE;
      end
      ST_MEM_RD: begin
        rsp_valid_d = 1'b1;
        rsp_data_d  = mem_dout;
        state_d     = ST_IDLE;
      end
      ST_SET_PC: begin
        remaining_d = cmd_q.data;
        retired_d   = '0;
        stop_req_d  = 1'b0;
        state_d     = ST_START;
      end
      ST_START: begin
        state_d = ST_RUNNING;
      end
      ST_RUNNING: begin
        if (accept) begin
          stop_req_d = 1'b1;
        end
        if (core_done) begin
          retired_d = sat_inc(retired_q);
          if (remaining_q != '0) begin
            remaining_d = remaining_q - DATA_W'(1);
          end
          // A boundary reached with run low is the last instruction.
          if (!core_run_q) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (core_halt) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = retired_q;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d       = (state_d != ST_IDLE);
    owner_d      = core_owns(state_d);
    own_we_d     = (state_d == ST_MEM_WR);
    pc_set_wr_d  = (state_d == ST_SET_PC);
    pc_set_val_d = pc_set_wr_d ? cmd_d.addr : '0;
    // Run is dropped once a stop is pending or the last counted instruction is in flight.
    core_run_d   = (state_d == ST_START) ||
                   ((state_d == ST_RUNNING) && !stop_req_d &&
                    !((cmd_d.data != '0) && (remaining_d == DATA_W'(1))));
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cmd_q        <= '0;
      remaining_q  <= '0;
      retired_q    <= '0;
      stop_req_q   <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      busy_q       <= 1'b0;
      owner_q      <= 1'b0;
      own_we_q     <= 1'b0;
      pc_set_val_q <= '0;
      pc_set_wr_q  <= 1'b0;
      core_run_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      remaining_q  <= remaining_d;
      retired_q    <= retired_d;
      stop_req_q   <= stop_req_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      busy_q       <= busy_d;
      owner_q      <= owner_d;
      own_we_q     <= own_we_d;
      pc_set_val_q <= pc_set_val_d;
      pc_set_wr_q  <= pc_set_wr_d;
      core_run_q   <= core_run_d;
    end
  end

  // Memory port ownership select.
  simproc_mem_mux u_mem_mux (
    .owner     (owner_q),
    .host_addr (cmd_q.addr),
    .host_din  (cmd_q.data),
    .host_we   (own_we_q),
    .core_addr (core_mem_addr),
    .core_din  (core_mem_din),
    .core_we   (core_mem_we),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_we    (mem_we)
  );

endmodule

// File: tb/tb_simproc_host_ctrl.sv
// Directed bench for simproc_host_ctrl with a small core and memory model.
module tb_simproc_host_ctrl;
  import simproc_pkg::*;

  logic       clk;
  logic       rst;
  logic       busy;
  logic [7:0] core_mem_addr, core_mem_din, core_mem_dout;
  logic       core_mem_we;
  logic [7:0] mem_addr, mem_din, mem_dout;
  logic       mem_we;
  logic [7:0] core_pc_set_val;
  logic       core_pc_set_wr, core_run, core_halt, core_done;

  simproc_host_ctrl_if host_if ();

  simproc_host_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .host            (host_if),
    .busy            (busy),
    .core_mem_addr   (core_mem_addr),
    .core_mem_din    (core_mem_din),
    .core_mem_we     (core_mem_we),
    .core_mem_dout   (core_mem_dout),
    .mem_addr        (mem_addr),
    .mem_din         (mem_din),
    .mem_we          (mem_we),
    .mem_dout        (mem_dout),
    .core_pc_set_val (core_pc_set_val),
    .core_pc_set_wr  (core_pc_set_wr),
    .core_run        (core_run),
    .core_halt       (core_halt),
    .core_done       (core_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: combinational read, synchronous write.
  logic [7:0] mem [256];
  assign mem_dout = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_din;

  // Core model: three cycles per instruction, done on the last; 0xFn jumps back by n-1.
  typedef enum logic [1:0] {C_IDLE, C_CYCLE_1, C_CYCLE_2, C_CYCLE_3} core_st_t;
  core_st_t   cst;
  logic [7:0] pc, ir;
  assign core_halt     = (cst == C_IDLE);
  assign core_done     = (cst == C_CYCLE_3);
  assign core_mem_addr = pc;
  assign core_mem_din  = 8'h00;
  assign core_mem_we   = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      cst <= C_IDLE;
      pc  <= 8'h00;
      ir  <= 8'h00;
    end else begin
      if (core_pc_set_wr) pc <= core_pc_set_val;
      case (cst)
        C_IDLE:    if (core_run) cst <= C_CYCLE_1;
        C_CYCLE_1: begin ir <= core_mem_dout; cst <= C_CYCLE_2; end
        C_CYCLE_2: cst <= C_CYCLE_3;
        C_CYCLE_3: begin
          pc  <= (ir[7:4] == 4'hF) ? pc + 8'd1 - {4'h0, ir[3:0]} : pc + 8'd1;
          cst <= core_run ? C_CYCLE_1 : C_IDLE;
        end
        default: cst <= C_IDLE;
      endcase
    end
  end

  // Event counters.
  int done_total = 0;
  int we_total   = 0;
  always @(posedge clk) begin
    if (core_done) done_total <= done_total + 1;
    if (mem_we)    we_total   <= we_total + 1;
  end

  // The core must already be halted when a RUN is taken.
  always @(posedge clk) begin
    if (!rst && host_if.cmd_valid && host_if.cmd_ready && host_if.cmd_op == OP_RUN)
      assert (core_halt) else $error("RUN accepted while core not halted");
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command and hold it until the accepting edge; returns one cycle after accept.
  task automatic send(input host_op_t op, input logic [7:0] a, input logic [7:0] d);
    int n;
    n = 0;
    host_if.cmd_valid = 1'b1;
    host_if.cmd_op    = op;
    host_if.cmd_addr  = a;
    host_if.cmd_data  = d;
    #1;
    while (!host_if.cmd_ready && n < 1000) begin tick(); n++; end
    if (!host_if.cmd_ready) chk("cmd_accept_timeout", 32'(host_if.cmd_ready), 32'd1);
    tick();
    host_if.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, output logic [7:0] d);
    int n;
    n = 0;
    while (!host_if.rsp_valid && n < 2000) begin tick(); n++; end
    chk({tag, "_rsp_seen"}, 32'(host_if.rsp_valid), 32'd1);
    d = host_if.rsp_data;
    tick();
  endtask

  initial begin
    logic [7:0] r;
    int base, base_we, expd;

    rst = 1'b1;
    host_if.cmd_valid = 1'b0;
    host_if.cmd_op    = OP_MEM_WR;
    host_if.cmd_addr  = 8'h00;
    host_if.cmd_data  = 8'h00;
    repeat (3) tick();
    rst = 1'b0;

    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_valid", 32'(host_if.rsp_valid), 32'd0);
    chk("rst_core_run", 32'(core_run), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_pc_set_wr", 32'(core_pc_set_wr), 32'd0);
    chk("rst_cmd_ready", 32'(host_if.cmd_ready), 32'd1);

    // MEM_WR 0x20 <= 0xA5
    base_we = we_total;
    send(OP_MEM_WR, 8'h20, 8'hA5);
    chk("wr_we_t1", 32'(mem_we), 32'd1);
    chk("wr_addr_t1", 32'(mem_addr), 32'h20);
    chk("wr_din_t1", 32'(mem_din), 32'hA5);
    chk("wr_rsp_early", 32'(host_if.rsp_valid), 32'd0);
    tick();
    chk("wr_rsp_t2", 32'(host_if.rsp_valid), 32'd1);
    chk("wr_rsp_data", 32'(host_if.rsp_data), 32'hA5);
    chk("wr_we_off", 32'(mem_we), 32'd0);
    chk("wr_we_count", 32'(we_total - base_we), 32'd1);

    // MEM_RD 0x20
    send(OP_MEM_RD, 8'h20, 8'h00);
    chk("rd_rsp_early", 32'(host_if.rsp_valid), 32'd0);
    tick();
    chk("rd_rsp_t2", 32'(host_if.rsp_valid), 32'd1);
    chk("rd_rsp_data", 32'(host_if.rsp_data), 32'hA5);
    tick();
    chk("rd_rsp_pulse", 32'(host_if.rsp_valid), 32'd0);

    // Self-loop program at 0x10
    send(OP_MEM_WR, 8'h10, 8'hF1);
    wait_rsp("load", r);

    // RUN 0x10 for 5 instructions
    base = done_total;
    send(OP_RUN, 8'h10, 8'h05);
    chk("run_pc_wr_t1", 32'(core_pc_set_wr), 32'd1);
    chk("run_pc_val_t1", 32'(core_pc_set_val), 32'h10);
    chk("run_busy_t1", 32'(busy), 32'd1);
    chk("run_core_run_t1", 32'(core_run), 32'd0);
    tick();
    chk("run_core_run_t2", 32'(core_run), 32'd1);
    chk("run_pc_wr_t2", 32'(core_pc_set_wr), 32'd0);
    tick();
    chk("run_core_active_t3", 32'(core_halt), 32'd0);
    wait_rsp("run5", r);
    chk("run5_rsp_data", 32'(r), 32'd5);
    chk("run5_done_count", 32'(done_total - base), 32'd5);
    chk("run5_halt", 32'(core_halt), 32'd1);
    chk("run5_pc", 32'(pc), 32'h10);
    chk("run5_busy", 32'(busy), 32'd0);

    // RUN count 1
    base = done_total;
    send(OP_RUN, 8'h10, 8'h01);
    wait_rsp("run1", r);
    chk("run1_rsp_data", 32'(r), 32'd1);
    chk("run1_done_count", 32'(done_total - base), 32'd1);

    // Free run, STOP after 40 cycles
    base = done_total;
    send(OP_RUN, 8'h10, 8'h00);
    repeat (40) tick();
    send(OP_STOP, 8'h00, 8'h00);
    wait_rsp("stop40", r);
    chk("stop40_rsp_vs_done", 32'(r), 32'(done_total - base));
    chk("stop40_range", 32'((done_total - base) >= 13 && (done_total - base) <= 14), 32'd1);
    chk("stop40_halt", 32'(core_halt), 32'd1);

    // STOP in the same cycle as a core_done: one more instruction retires
    base = done_total;
    send(OP_RUN, 8'h10, 8'h00);
    repeat (10) tick();
    begin
      int n;
      n = 0;
      while (!core_done && n < 100) begin tick(); n++; end
      chk("stopdone_seen", 32'(core_done), 32'd1);
    end
    expd = done_total - base + 2;
    send(OP_STOP, 8'h00, 8'h00);
    wait_rsp("stopdone", r);
    chk("stopdone_rsp_data", 32'(r), 32'(expd));
    chk("stopdone_done_count", 32'(done_total - base), 32'(expd));

    // Long free run saturates the retired count
    base = done_total;
    send(OP_RUN, 8'h10, 8'h00);
    repeat (820) tick();
    send(OP_STOP, 8'h00, 8'h00);
    wait_rsp("sat", r);
    chk("sat_rsp_data", 32'(r), 32'hFF);
    chk("sat_done_over", 32'((done_total - base) > 255), 32'd1);

    // STOP in IDLE is a no-op with a zero response
    send(OP_STOP, 8'h00, 8'h00);
    chk("idle_stop_rsp", 32'(host_if.rsp_valid), 32'd1);
    chk("idle_stop_data", 32'(host_if.rsp_data), 32'h00);
    chk("idle_stop_busy", 32'(busy), 32'd0);
    tick();

    // Reset in the middle of a run
    send(OP_RUN, 8'h10, 8'h00);
    repeat (20) tick();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    chk("mid_rst_core_run", 32'(core_run), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_rsp_valid", 32'(host_if.rsp_valid), 32'd0);
    rst = 1'b0;
    tick();
    send(OP_MEM_RD, 8'h20, 8'h00);
    tick();
    chk("post_rst_rd_valid", 32'(host_if.rsp_valid), 32'd1);
    chk("post_rst_rd_data", 32'(host_if.rsp_data), 32'hA5);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
